// File: rtl/ee354_numlock_pkg.sv
// ee354_numlock_pkg
//   Shared definitions for the parametrised number lock: the state encoding
//   exposed on q_state and small constant functions used to size counters.
package ee354_numlock_pkg;

  // State encoding; the values are visible on the q_state debug port.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESS   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_BAD     = 3'd3,
    ST_OPEN    = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_e;

  // Ceiling log2: number of bits needed to index 'value' distinct items.
  // clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 32'sd0;
    rem = value - 32'sd1;
    while (rem > 32'sd0) begin
      res = res + 32'sd1;
      rem = rem >>> 1;
    end
    return res;
  endfunction

  // Larger of two integers, for sizing a counter shared by two durations.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ee354_numlock_timer.sv
// ee354_numlock_timer
//   Loadable down-counter with a zero flag. Shared by the OPEN window and the
//   LOCKOUT window of the number lock; it parks at zero once it gets there.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (count -> 0)
//   load     in   load load_val this edge (has priority over dec)
//   dec      in   decrement this edge if not already zero
//   load_val in   WIDTH-bit value to load
//   zero     out  count is zero (decode of the count register)
module ee354_numlock_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] NONE = {WIDTH{1'b0}};

  logic [WIDTH-1:0] count_r;

  // Count register: load wins, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= NONE;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != NONE)) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == NONE);

endmodule

// File: rtl/ee354_numlock_param_sm.sv
// ee354_numlock_param_sm
//   Parametrised number lock. A CODE_LEN-digit binary combination is keyed
//   on two buttons (U = 1, Z = 0), MSB first. A full correct entry opens the
//   lock for OPEN_CYCLES cycles; MAX_TRIES consecutive wrong entries hold the
//   lock in LOCKOUT for LOCKOUT_CYCLES cycles. The combination can be
//   reloaded from Code_in while the lock is open.
// Ports:
//   Clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   U, Z       in   debounced "1" / "0" buttons, high while held
//   Code_in    in   new combination (CODE_LEN bits)
//   Code_ld    in   load strobe, only honoured while open
//   Unlock     out  high exactly while open
//   Locked_out out  high exactly while locked out
//   q_state    out  encoded state (ee354_numlock_pkg::state_e)
//   Digit_idx  out  correct digits accepted so far
//   Fail_cnt   out  consecutive failed entries (saturating)
module ee354_numlock_param_sm
  import ee354_numlock_pkg::*;
#(
  parameter int                  CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0] CODE_INIT      = 4'b1011,
  parameter int                  OPEN_CYCLES    = 16,
  parameter int                  MAX_TRIES      = 3,
  parameter int                  LOCKOUT_CYCLES = 64
) (
  input  logic                              Clk,
  input  logic                              reset_n,
  input  logic                              U,
  input  logic                              Z,
  input  logic [CODE_LEN-1:0]               Code_in,
  input  logic                              Code_ld,
  output logic                              Unlock,
  output logic                              Locked_out,
  output logic [2:0]                        q_state,
  output logic [clog2(CODE_LEN+1)-1:0]      Digit_idx,
  output logic [clog2(MAX_TRIES+1)-1:0]     Fail_cnt
);

  localparam int DIG_W  = clog2(CODE_LEN + 1);
  localparam int FAIL_W = clog2(MAX_TRIES + 1);
  localparam int TMR_W  = max2(32'sd1, clog2(max2(OPEN_CYCLES, LOCKOUT_CYCLES)));

  localparam logic [DIG_W-1:0]    DIG_ZERO  = {DIG_W{1'b0}};
  localparam logic [DIG_W-1:0]    DIG_ONE   = DIG_W'(1'b1);
  localparam logic [DIG_W-1:0]    DIG_FULL  = DIG_W'(CODE_LEN);
  localparam logic [FAIL_W-1:0]   FAIL_ZERO = {FAIL_W{1'b0}};
  localparam logic [FAIL_W-1:0]   FAIL_ONE  = FAIL_W'(1'b1);
  localparam logic [FAIL_W-1:0]   FAIL_MAX  = FAIL_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0]    OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0]    LOCK_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CODE_LEN-1:0] MSB_MASK  = CODE_LEN'(1'b1) << (CODE_LEN - 1);

  state_e              state_r;
  state_e              state_nxt_s;
  logic [DIG_W-1:0]    digit_r;
  logic [DIG_W-1:0]    digit_nxt_s;
  logic [DIG_W-1:0]    digit_inc_s;
  logic [FAIL_W-1:0]   fail_r;
  logic [FAIL_W-1:0]   fail_nxt_s;
  logic [FAIL_W-1:0]   fail_inc_s;
  logic [CODE_LEN-1:0] code_r;
  logic                unlock_r;
  logic                locked_r;
  logic                exp_bit_s;
  logic                any_s;
  logic                both_s;
  logic                hit_s;
  logic                tmr_load_s;
  logic [TMR_W-1:0]    tmr_val_s;
  logic                tmr_dec_s;
  logic                tmr_zero_s;

  // Expected digit is code_r[CODE_LEN-1-digit_r]; a walking mask avoids an
  // index subtraction and keeps every code bit in use.
  assign exp_bit_s   = |(code_r & (MSB_MASK >> digit_r));
  assign any_s       = U | Z;
  assign both_s      = U & Z;
  // A hit is exactly one button down and it matches the expected digit.
  assign hit_s       = (U ^ Z) & (U == exp_bit_s);
  assign digit_inc_s = digit_r + DIG_ONE;
  assign fail_inc_s  = (fail_r == FAIL_MAX) ? fail_r : (fail_r + FAIL_ONE);
  assign tmr_dec_s   = (state_r == ST_OPEN) | (state_r == ST_LOCKOUT);

  // Next-state and counter update rules.
  always_comb begin
    state_nxt_s = state_r;
    digit_nxt_s = digit_r;
    fail_nxt_s  = fail_r;
    tmr_load_s  = 1'b0;
    tmr_val_s   = OPEN_LOAD;
    case (state_r)
      ST_IDLE, ST_WAIT: begin
        if (both_s || (any_s && !hit_s)) begin
          state_nxt_s = ST_BAD;
          digit_nxt_s = DIG_ZERO;
          fail_nxt_s  = fail_inc_s;
        end else if (hit_s) begin
          state_nxt_s = ST_PRESS;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_PRESS: begin
        // The digit counts on release; extra buttons while held are ignored.
        if (any_s) begin
          state_nxt_s = ST_PRESS;
        end else if (digit_inc_s == DIG_FULL) begin
          state_nxt_s = ST_OPEN;
          digit_nxt_s = DIG_ZERO;
          fail_nxt_s  = FAIL_ZERO;
          tmr_load_s  = 1'b1;
          tmr_val_s   = OPEN_LOAD;
        end else begin
          state_nxt_s = ST_WAIT;
          digit_nxt_s = digit_inc_s;
        end
      end
      ST_BAD: begin
        if (any_s) begin
          state_nxt_s = ST_BAD;
        end else if (fail_r == FAIL_MAX) begin
          state_nxt_s = ST_LOCKOUT;
          tmr_load_s  = 1'b1;
          tmr_val_s   = LOCK_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_OPEN: begin
        if (tmr_zero_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OPEN;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_zero_s) begin
          state_nxt_s = ST_IDLE;
          fail_nxt_s  = FAIL_ZERO;
        end else begin
          state_nxt_s = ST_LOCKOUT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        digit_nxt_s = DIG_ZERO;
        fail_nxt_s  = FAIL_ZERO;
      end
    endcase
  end

  // State, counters, combination register and registered status outputs.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      digit_r  <= DIG_ZERO;
      fail_r   <= FAIL_ZERO;
      code_r   <= CODE_INIT;
      unlock_r <= 1'b0;
      locked_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      digit_r  <= digit_nxt_s;
      fail_r   <= fail_nxt_s;
      unlock_r <= (state_nxt_s == ST_OPEN);
      locked_r <= (state_nxt_s == ST_LOCKOUT);
      // Reload is accepted on any OPEN cycle, including the last one.
      if ((state_r == ST_OPEN) && Code_ld) begin
        code_r <= Code_in;
      end else begin
        code_r <= code_r;
      end
    end
  end

  ee354_numlock_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk      (Clk),
    .rst_n    (reset_n),
    .load     (tmr_load_s),
    .dec      (tmr_dec_s),
    .load_val (tmr_val_s),
    .zero     (tmr_zero_s)
  );

  assign Unlock     = unlock_r;
  assign Locked_out = locked_r;
  assign q_state    = state_r;
  assign Digit_idx  = digit_r;
  assign Fail_cnt   = fail_r;

endmodule

// File: tb/tb_ee354_numlock_param_sm.sv
// tb_ee354_numlock_param_sm
//   Two lock instances (default parameters, and a 6-digit / 3-cycle variant)
//   driven by directed button sequences. An entry-level model of the lock is
//   compared against both instances every cycle; literal expectations pin
//   window lengths and key counter values.
module tb_ee354_numlock_param_sm;

  localparam int MAXT  = 3;
  localparam int LOCKC = 64;

  logic       Clk = 1'b0;
  logic       rst_a = 1'b0, rst_b = 1'b0;
  logic       u_a = 1'b0, z_a = 1'b0, ld_a = 1'b0;
  logic       u_b = 1'b0, z_b = 1'b0, ld_b = 1'b0;
  logic [3:0] cin_a = 4'b0000;
  logic [5:0] cin_b = 6'b000000;
  logic       unlock_a, lock_a, unlock_b, lock_b;
  logic [2:0] q_a, q_b, dig_a, dig_b;
  logic [1:0] fail_a, fail_b;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #10 Clk = ~Clk;

  ee354_numlock_param_sm dut_a (
    .Clk(Clk), .reset_n(rst_a), .U(u_a), .Z(z_a), .Code_in(cin_a), .Code_ld(ld_a),
    .Unlock(unlock_a), .Locked_out(lock_a), .q_state(q_a), .Digit_idx(dig_a), .Fail_cnt(fail_a)
  );

  ee354_numlock_param_sm #(
    .CODE_LEN(6), .CODE_INIT(6'b101100), .OPEN_CYCLES(3)
  ) dut_b (
    .Clk(Clk), .reset_n(rst_b), .U(u_b), .Z(z_b), .Code_in(cin_b), .Code_ld(ld_b),
    .Unlock(unlock_b), .Locked_out(lock_b), .q_state(q_b), .Digit_idx(dig_b), .Fail_cnt(fail_b)
  );

  // ---------------- entry-level model ----------------
  // open/lock hold the remaining window length, prog the correct digits so
  // far, hold a correct digit still pressed, bad a wrong entry still pressed.
  int         p_len  [2] = '{4, 6};
  int         p_open [2] = '{16, 3};
  int         m_open [2];
  int         m_lock [2];
  int         m_prog [2];
  int         m_fail [2];
  bit         m_hold [2];
  bit         m_bad  [2];
  logic [15:0] m_code [2];

  task automatic mreset(input int i);
    m_open[i] = 0; m_lock[i] = 0; m_prog[i] = 0; m_fail[i] = 0;
    m_hold[i] = 1'b0; m_bad[i] = 1'b0;
    m_code[i] = (i == 0) ? 16'h000B : 16'h002C;
  endtask

  task automatic mstep(input int i);
    logic uu, zz, ldd, expb;
    logic [15:0] cin;
    if (i == 0) begin uu = u_a; zz = z_a; ldd = ld_a; cin = {12'd0, cin_a}; end
    else        begin uu = u_b; zz = z_b; ldd = ld_b; cin = {10'd0, cin_b}; end
    if (m_open[i] > 0) begin
      if (ldd) m_code[i] = cin;
      m_open[i] = m_open[i] - 1;
    end else if (m_lock[i] > 0) begin
      m_lock[i] = m_lock[i] - 1;
      if (m_lock[i] == 0) m_fail[i] = 0;
    end else if (m_bad[i]) begin
      if (!uu && !zz) begin
        m_bad[i] = 1'b0;
        if (m_fail[i] == MAXT) m_lock[i] = LOCKC;
      end
    end else if (m_hold[i]) begin
      if (!uu && !zz) begin
        m_hold[i] = 1'b0;
        m_prog[i] = m_prog[i] + 1;
        if (m_prog[i] == p_len[i]) begin
          m_prog[i] = 0; m_fail[i] = 0; m_open[i] = p_open[i];
        end
      end
    end else begin
      expb = m_code[i][p_len[i] - 1 - m_prog[i]];
      if ((uu && zz) || ((uu ^ zz) && (uu != expb))) begin
        m_bad[i] = 1'b1;
        m_prog[i] = 0;
        if (m_fail[i] < MAXT) m_fail[i] = m_fail[i] + 1;
      end else if (uu ^ zz) begin
        m_hold[i] = 1'b1;
      end
    end
  endtask

  function automatic int m_q(input int i);
    if (m_open[i] > 0) return 4;
    if (m_lock[i] > 0) return 5;
    if (m_bad[i])      return 3;
    if (m_hold[i])     return 1;
    if (m_prog[i] > 0) return 2;
    return 0;
  endfunction

  always @(posedge Clk or negedge rst_a) begin
    if (!rst_a) mreset(0); else mstep(0);
  end

  always @(posedge Clk or negedge rst_b) begin
    if (!rst_b) mreset(1); else mstep(1);
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("a.unlock",  int'(unlock_a), int'(m_open[0] > 0));
      chk("a.locked",  int'(lock_a),   int'(m_lock[0] > 0));
      chk("a.q_state", int'(q_a),      m_q(0));
      chk("a.digit",   int'(dig_a),    m_prog[0]);
      chk("a.fail",    int'(fail_a),   m_fail[0]);
      chk("b.unlock",  int'(unlock_b), int'(m_open[1] > 0));
      chk("b.locked",  int'(lock_b),   int'(m_lock[1] > 0));
      chk("b.q_state", int'(q_b),      m_q(1));
      chk("b.digit",   int'(dig_b),    m_prog[1]);
      chk("b.fail",    int'(fail_b),   m_fail[1]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic set_btn(input int i, input logic uv, input logic zv);
    if (i == 0) begin u_a = uv; z_a = zv; end
    else        begin u_b = uv; z_b = zv; end
  endtask

  // Press, hold for 'hold' edges, release, and let the release register.
  task automatic btn(input int i, input logic uv, input logic zv, input int hold);
    set_btn(i, uv, zv);
    repeat (hold) tick();
    set_btn(i, 1'b0, 1'b0);
    tick();
  endtask

  task automatic enter(input int i, input logic [15:0] code, input int len);
    for (int k = len - 1; k >= 0; k--) btn(i, code[k], ~code[k], 1);
  endtask

  // Count cycles Unlock stays high from now, bounded.
  task automatic count_open(input int i, output int n);
    n = 0;
    while (((i == 0) ? unlock_a : unlock_b) && n < 200) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) tick();
    cmp_en = 1'b1;
    chk("rst.q_state", int'(q_a), 0);
    chk("rst.unlock", int'(unlock_a), 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();

    // 1011 opens for 16 cycles starting right after the final release.
    enter(0, 16'h000B, 4);
    chk("t1.unlock_first", int'(unlock_a), 1);
    chk("t1.fail", int'(fail_a), 0);
    count_open(0, n);
    chk("t1.open_len", n, 16);

    // 1,1 -> bad on the second press, then a good entry clears Fail_cnt.
    btn(0, 1'b1, 1'b0, 1);
    set_btn(0, 1'b1, 1'b0);
    tick();
    chk("t2.bad_state", int'(q_a), 3);
    chk("t2.fail", int'(fail_a), 1);
    set_btn(0, 1'b0, 1'b0);
    tick();
    chk("t2.idle", int'(q_a), 0);
    enter(0, 16'h000B, 4);
    chk("t2.reopen", int'(unlock_a), 1);
    chk("t2.fail_clr", int'(fail_a), 0);
    count_open(0, n);

    // Three wrong first digits -> lockout for 64 cycles, U presses ignored.
    for (int t = 1; t <= 3; t++) begin
      btn(0, 1'b0, 1'b1, 1);
      chk("t3.fail_step", int'(fail_a), t);
    end
    chk("t3.locked_first", int'(lock_a), 1);
    n = 0;
    while (lock_a && n < 200) begin
      u_a = (n < 60) ? n[1] : 1'b0;
      n++;
      tick();
    end
    u_a = 1'b0;
    chk("t3.lock_len", n, 64);
    chk("t3.fail_after", int'(fail_a), 0);
    chk("t3.idle_after", int'(q_a), 0);

    // U and Z together after one correct digit.
    btn(0, 1'b1, 1'b0, 1);
    chk("t4.digit1", int'(dig_a), 1);
    set_btn(0, 1'b1, 1'b1);
    tick();
    chk("t4.bad_state", int'(q_a), 3);
    chk("t4.digit0", int'(dig_a), 0);
    set_btn(0, 1'b0, 1'b0);
    tick();

    // Reload 0110 while open; old code then fails, new one opens.
    enter(0, 16'h000B, 4);
    ld_a = 1'b1; cin_a = 4'b0110;
    tick();
    ld_a = 1'b0;
    count_open(0, n);
    set_btn(0, 1'b1, 1'b0);
    tick();
    chk("t5.old_code_bad", int'(q_a), 3);
    set_btn(0, 1'b0, 1'b0);
    tick();
    ld_a = 1'b1; cin_a = 4'b0000;   // ignored outside OPEN
    tick();
    ld_a = 1'b0;
    enter(0, 16'h0006, 4);
    chk("t5.new_code_open", int'(unlock_a), 1);
    // Load on the final OPEN cycle is still taken.
    repeat (15) tick();
    chk("t5.last_open_cycle", int'(unlock_a), 1);
    ld_a = 1'b1; cin_a = 4'b1111;
    tick();
    ld_a = 1'b0;
    chk("t5.closed", int'(unlock_a), 0);
    enter(0, 16'h000F, 4);
    chk("t5.last_cycle_load", int'(unlock_a), 1);
    count_open(0, n);

    // 6-digit instance: 3-cycle window, reset mid-OPEN drops Unlock at once.
    enter(1, 16'h002C, 6);
    chk("t6.unlock_first", int'(unlock_b), 1);
    count_open(1, n);
    chk("t6.open_len", n, 3);
    enter(1, 16'h002C, 6);
    ld_b = 1'b1; cin_b = 6'b000111;
    tick();
    ld_b = 1'b0;
    chk("t6.still_open", int'(unlock_b), 1);
    #4;
    rst_b = 1'b0;
    #1;
    chk("t6.async_unlock", int'(unlock_b), 0);
    chk("t6.async_state", int'(q_b), 0);
    tick();
    rst_b = 1'b1;
    tick();
    enter(1, 16'h002C, 6);
    chk("t6.init_code_back", int'(unlock_b), 1);
    count_open(1, n);
    tick();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
